instr_fetch_unit: RTL

Upstream neighbour of the opcode decoder in the single-cycle RISC-V core. Owns the program counter and fetches 32-bit instructions from instruction memory over a request/grant/rvalid interface. Presents one instruction at a time to decode/execute with a valid/ready handshake. Computes the next PC from sequential increment or a resolved branch, and flags misaligned-target and memory-timeout faults.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid and hands one
// instruction at a time to decode/execute with a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned            XLEN           = 32,
  parameter logic [XLEN-1:0]        RESET_PC       = '0,
  parameter logic [31:0]            NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned            TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID, S_FAULT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            discard_q, discard_d;

  logic [XLEN-1:0] retire_pc;
  logic            flush_mis;
  logic            timeout;

  assign retire_pc = branch_taken ? branch_target : pc_q + XLEN'(4);
  assign flush_mis = (flush_pc[1:0] != 2'b00);
  assign timeout   = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic; flush outranks retire, misaligned redirects fault immediately
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;

    unique case (state_q)
      S_FETCH: begin
        if (flush) begin
          pc_d = flush_pc;
          if (flush_mis) begin
            state_d = S_FAULT;
            cause_d = CAUSE_MISALIGN;
          end else if (imem_gnt) begin
            // Request accepted with the old address: its data must be dropped
            state_d   = S_WAIT;
            cnt_d     = '0;
            discard_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          discard_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (flush && flush_mis) begin
          pc_d      = flush_pc;
          state_d   = S_FAULT;
          cause_d   = CAUSE_MISALIGN;
          discard_d = 1'b0;
        end else if (flush) begin
          pc_d = flush_pc;
          if (imem_rvalid) begin
            state_d   = S_FETCH;
            discard_d = 1'b0;
          end else if (timeout) begin
            state_d = S_FAULT;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            discard_d = 1'b1;
            cnt_d     = cnt_q + CW'(1);
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            state_d   = S_FETCH;
            discard_d = 1'b0;
          end else begin
            state_d = S_VALID;
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_VALID: begin
        if (flush || instr_ready) begin
          pc_d    = flush ? flush_pc : retire_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (flush ? flush_mis : (retire_pc[1:0] != 2'b00)) begin
            state_d = S_FAULT;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FAULT: begin
      end

      default: state_d = S_FAULT;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH) & ~rst;
  assign imem_addr   = {pc_q[XLEN-1:2], 2'b00};
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign fetch_fault = (state_q == S_FAULT);
  assign fault_cause = cause_q;

endmodule
